cpu_sequencer: RTL

Fetch/decode/execute controller for the 8-bit mini CPU. Steps a program counter through program memory and latches each 4-bit opcode into an instruction register that drives the instruction decoder. It then gates the decoder's CLR/En outputs so that datapath registers load for exactly one cycle per instruction. It sits between program memory, the instruction decoder and the register/ALU datapath, and is started and monitored by the top level through a Start/Busy/Done handshake.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/cpu_sequencer_seq_pc.sv | 34 +++
 rtl/cpu_sequencer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 8-bit mini CPU control path.
//   - seq_state_t : sequencer FSM states (ST_PAUSE is only reachable when
//                   SEQ_SINGLE_STEP_EN is defined)
//   - OP_HALT     : opcode that ends a run without enabling the datapath
//   - OP_*        : datapath opcodes understood by the instruction decoder
package cpu_pkg;

    localparam int OPCODE_W = 4;
    localparam int REG_EN_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_DONE  = 3'd4,
        ST_PAUSE = 3'd5
    } seq_state_t;

    localparam logic [OPCODE_W-1:0] OP_CLR  = 4'b0000;
    localparam logic [OPCODE_W-1:0] OP_LDA  = 4'b0001;
    localparam logic [OPCODE_W-1:0] OP_LDB  = 4'b0010;
    localparam logic [OPCODE_W-1:0] OP_MOV  = 4'b0011;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 4'b0100;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 4'b0110;
    localparam logic [OPCODE_W-1:0] OP_AND  = 4'b0111;
    localparam logic [OPCODE_W-1:0] OP_OR   = 4'b1000;
    localparam logic [OPCODE_W-1:0] OP_XOR  = 4'b1001;
    localparam logic [OPCODE_W-1:0] OP_NOT  = 4'b1010;
    localparam logic [OPCODE_W-1:0] OP_HALT = 4'b1111;

endpackage

// File: rtl/cpu_sequencer_seq_pc.sv
// seq_pc: program counter for cpu_sequencer.
//   clk    - clock, rising edge
//   reset  - synchronous active-high clear
//   clr    - synchronous clear to address 0
//   inc    - advance by one (never past PROG_LEN-1, so the PC cannot wrap)
//   pc     - current program address
//   last   - pc is the final program word (PROG_LEN-1)
module seq_pc
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int PROG_LEN = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc,
    output logic              last
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PROG_LEN - 1);

    assign last = (pc == LAST_ADDR);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            pc <= '0;
        end else if (inc && !last) begin
            pc <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/load/execute controller for the 8-bit mini CPU.
//   Clk, Reset   - clock and synchronous active-high reset
//   Start        - level-sampled run request, honoured only in IDLE
//   ProgAddr     - program-memory address (the PC)
//   ProgData     - program-memory data, valid one cycle after ProgAddr
//   Instruction  - instruction register driving the decoder
//   DecCLR/DecEn - decoder outputs for the current Instruction
//   RegCLR/RegEn - decoder outputs gated to the single EXEC cycle
//   Busy, Done   - run in progress / one-cycle end-of-run pulse
//   Step         - only with SEQ_SINGLE_STEP_EN: releases the PAUSE state
// Optional feature macro: SEQ_SINGLE_STEP_EN (adds Step and the PAUSE state).
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int PROG_LEN = 16
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Start,
    output logic [ADDR_W-1:0]   ProgAddr,
    input  logic [OPCODE_W-1:0] ProgData,
    output logic [OPCODE_W-1:0] Instruction,
    input  logic                DecCLR,
    input  logic [REG_EN_W-1:0] DecEn,
    output logic                RegCLR,
    output logic [REG_EN_W-1:0] RegEn,
    output logic                Busy,
    output logic                Done
`ifdef SEQ_SINGLE_STEP_EN
    ,
    input  logic                Step
`endif
);

    seq_state_t        state;
    logic [ADDR_W-1:0] pc;
    logic              pc_last;
    logic              pc_clr;
    logic              pc_inc;
    logic              is_halt;
    logic              exec_live;

    assign is_halt   = (Instruction == OP_HALT);
    // The datapath only ever sees enables in EXEC, and never for HALT.
    assign exec_live = (state == ST_EXEC) && !is_halt;

    // PC is parked at 0 while idle; clearing during DONE leaves the final
    // address visible for the Done cycle.
    assign pc_clr = (state == ST_IDLE) || (state == ST_DONE);
    assign pc_inc = exec_live && !pc_last;

    seq_pc #(
        .ADDR_W   (ADDR_W),
        .PROG_LEN (PROG_LEN)
    ) u_pc (
        .clk   (Clk),
        .reset (Reset),
        .clr   (pc_clr),
        .inc   (pc_inc),
        .pc    (pc),
        .last  (pc_last)
    );

    assign ProgAddr = pc;
    assign RegEn    = exec_live ? DecEn : '0;
    assign RegCLR   = exec_live & DecCLR;

    // Busy and Done are registered alongside the state transition so they
    // change on the same edge as the state they describe.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= ST_IDLE;
            Instruction <= '0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        state <= ST_FETCH;
                        Busy  <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    Instruction <= ProgData;
                    state       <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (is_halt || pc_last) begin
                        state <= ST_DONE;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                    end else begin
`ifdef SEQ_SINGLE_STEP_EN
                        state <= ST_PAUSE;
`else
                        state <= ST_FETCH;
`endif
                    end
                end
`ifdef SEQ_SINGLE_STEP_EN
                ST_PAUSE: begin
                    if (Step) begin
                        state <= ST_FETCH;
                    end
                end
`endif
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
